// File: rtl/hex_scroll_ctrl.sv
// Scrolling hex message controller. Digits are appended into a small buffer
// and then scrolled right-to-left across six active-low seven-segment displays.
module hex_scroll_ctrl #(
   parameter int TICK_DIV = 25000000,
   parameter int MSG_MAX  = 16
) (
   input  logic       CLOCK_50,
   input  logic       Resetn,
   input  logic       wr_en,
   input  logic [3:0] wr_data,
   input  logic       start,
   input  logic       pause,
   input  logic       clear,
   input  logic [1:0] speed,
   output logic       wr_ready,
   output logic       busy,
   output logic [4:0] len,
   output logic [6:0] HEX0,
   output logic [6:0] HEX1,
   output logic [6:0] HEX2,
   output logic [6:0] HEX3,
   output logic [6:0] HEX4,
   output logic [6:0] HEX5
);

   localparam int AW = (MSG_MAX > 1) ? $clog2(MSG_MAX) : 1;
   localparam int PW = $clog2(MSG_MAX + 6);
   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_t;

   state_t        state;
   state_t        state_nxt;
   logic [3:0]    buffer [0:(1<<AW)-1];
   logic [PW-1:0] pos;
   logic [PW-1:0] pos_last;
   logic [PW-1:0] base;
   logic [CW-1:0] presc;
   logic [1:0]    step_cnt;
   logic          tick;
   logic [6:0]    hex_q   [6];
   logic [6:0]    hex_nxt [6];

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'h0: seg7 = 7'h40;
         4'h1: seg7 = 7'h79;
         4'h2: seg7 = 7'h24;
         4'h3: seg7 = 7'h30;
         4'h4: seg7 = 7'h19;
         4'h5: seg7 = 7'h12;
         4'h6: seg7 = 7'h02;
         4'h7: seg7 = 7'h78;
         4'h8: seg7 = 7'h00;
         4'h9: seg7 = 7'h10;
         4'hA: seg7 = 7'h08;
         4'hB: seg7 = 7'h03;
         4'hC: seg7 = 7'h46;
         4'hD: seg7 = 7'h21;
         4'hE: seg7 = 7'h06;
         default: seg7 = 7'h0E;
      endcase
   endfunction

   assign wr_ready = (state == IDLE) && (len < 5'(MSG_MAX)) && !start && !clear;
   assign tick     = (state == RUN) && (presc == CW'(TICK_DIV - 1));
   assign pos_last = PW'(len) + PW'(5);

   always_comb begin
      state_nxt = state;
      if (clear)
         state_nxt = IDLE;
      else if (start) begin
         if (state == IDLE && len != 5'd0)
            state_nxt = RUN;
      end else if (pause) begin
         if (state == RUN)
            state_nxt = PAUSE;
         else if (state == PAUSE)
            state_nxt = RUN;
      end
   end

   // Prescaler keeps counting on the cycle a pause is requested, so run time
   // accumulated before and after a pause adds up to exactly one step period.
   always_ff @(posedge CLOCK_50 or negedge Resetn) begin
      if (!Resetn) begin
         state    <= IDLE;
         busy     <= 1'b0;
         len      <= 5'd0;
         pos      <= '0;
         presc    <= '0;
         step_cnt <= 2'd0;
      end else begin
         state <= state_nxt;
         busy  <= (state_nxt != IDLE);
         if (clear) begin
            len      <= 5'd0;
            pos      <= '0;
            presc    <= '0;
            step_cnt <= 2'd0;
         end else if (start && state == IDLE && len != 5'd0) begin
            pos      <= '0;
            presc    <= '0;
            step_cnt <= 2'd0;
         end else begin
            if (state == RUN) begin
               presc <= tick ? '0 : presc + 1'b1;
               if (tick) begin
                  if (step_cnt >= speed) begin
                     step_cnt <= 2'd0;
                     pos      <= (pos >= pos_last) ? '0 : pos + 1'b1;
                  end else begin
                     step_cnt <= step_cnt + 2'd1;
                  end
               end
            end
            if (wr_en && wr_ready)
               len <= len + 5'd1;
         end
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (wr_en && wr_ready)
         buffer[len[AW-1:0]] <= wr_data;
   end

   // IDLE shows the entry right-justified; RUN/PAUSE shows the scroll window.
   always_comb begin
      base = (state == IDLE) ? PW'(len) : pos;
      for (int k = 0; k < 6; k++) begin
         hex_nxt[k] = 7'h7F;
         if (int'(base) > k && (int'(base) - 1 - k) < int'(len))
            hex_nxt[k] = seg7(buffer[AW'(int'(base) - 1 - k)]);
      end
   end

   always_ff @(posedge CLOCK_50 or negedge Resetn) begin
      if (!Resetn) begin
         for (int k = 0; k < 6; k++)
            hex_q[k] <= 7'h7F;
      end else begin
         for (int k = 0; k < 6; k++)
            hex_q[k] <= hex_nxt[k];
      end
   end

   assign HEX0 = hex_q[0];
   assign HEX1 = hex_q[1];
   assign HEX2 = hex_q[2];
   assign HEX3 = hex_q[3];
   assign HEX4 = hex_q[4];
   assign HEX5 = hex_q[5];

endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// Directed bench for hex_scroll_ctrl with a short prescaler (TICK_DIV=4).
module tb_hex_scroll_ctrl;

   logic       CLOCK_50;
   logic       Resetn;
   logic       wr_en;
   logic [3:0] wr_data;
   logic       start;
   logic       pause;
   logic       clear;
   logic [1:0] speed;
   logic       wr_ready;
   logic       busy;
   logic [4:0] len;
   logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

   int checks = 0;
   int errors = 0;

   hex_scroll_ctrl #(.TICK_DIV(4), .MSG_MAX(16)) dut (
      .CLOCK_50 (CLOCK_50),
      .Resetn   (Resetn),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .start    (start),
      .pause    (pause),
      .clear    (clear),
      .speed    (speed),
      .wr_ready (wr_ready),
      .busy     (busy),
      .len      (len),
      .HEX0     (HEX0),
      .HEX1     (HEX1),
      .HEX2     (HEX2),
      .HEX3     (HEX3),
      .HEX4     (HEX4),
      .HEX5     (HEX5)
   );

   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   task automatic tick();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic write_digit(input logic [3:0] d);
      wr_en   = 1'b1;
      wr_data = d;
      tick();
      wr_en   = 1'b0;
   endtask

   task automatic clear_pulse();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   task automatic start_pulse();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      Resetn = 1'b0; wr_en = 1'b0; wr_data = 4'h0;
      start = 1'b0; pause = 1'b0; clear = 1'b0; speed = 2'd0;
      tick();
      tick();
      check("rst_busy", busy, 8'h00);
      check("rst_len", len, 8'h00);
      check("rst_hex0", HEX0, 8'h7F);
      check("rst_hex5", HEX5, 8'h7F);
      Resetn = 1'b1;

      // Entry display, right-justified
      write_digit(4'h1);
      write_digit(4'h2);
      write_digit(4'h3);
      check("len3", len, 8'd3);
      tick();
      check("idle_hex0", HEX0, 8'h30);
      check("idle_hex1", HEX1, 8'h24);
      check("idle_hex2", HEX2, 8'h79);
      check("idle_hex3", HEX3, 8'h7F);
      check("idle_hex5", HEX5, 8'h7F);
      check("idle_busy", busy, 8'h00);

      // Buffer full, 17th write dropped
      clear_pulse();
      check("clear_len", len, 8'd0);
      for (int i = 0; i < 16; i++)
         write_digit(4'(i));
      check("full_len", len, 8'd16);
      wr_en = 1'b1; wr_data = 4'h0;
      check("full_wr_ready", wr_ready, 8'h00);
      tick();
      wr_en = 1'b0;
      check("drop_len", len, 8'd16);
      check("full_hex0", HEX0, 8'h0E);
      check("full_hex1", HEX1, 8'h06);

      // Scroll A,b at speed 0
      clear_pulse();
      write_digit(4'hA);
      write_digit(4'hB);
      speed = 2'd0;
      start_pulse();
      check("run_busy", busy, 8'h01);
      tick();
      check("run_e1_hex0", HEX0, 8'h7F);
      check("run_e1_hex1", HEX1, 8'h7F);
      repeat (3) tick();
      check("run_e4_hex0", HEX0, 8'h7F);
      tick();
      check("run_e5_hex0", HEX0, 8'h08);
      check("run_e5_hex1", HEX1, 8'h7F);
      repeat (4) tick();
      check("run_e9_hex1", HEX1, 8'h08);
      check("run_e9_hex0", HEX0, 8'h03);
      repeat (20) tick();
      check("pos7_hex5", HEX5, 8'h03);
      check("pos7_hex4", HEX4, 8'h7F);
      repeat (4) tick();
      check("wrap_hex0", HEX0, 8'h7F);
      check("wrap_hex5", HEX5, 8'h7F);
      repeat (4) tick();
      check("loop_hex0", HEX0, 8'h08);

      // Pause/resume at speed 3 (16 run cycles per step)
      clear_pulse();
      write_digit(4'hA);
      write_digit(4'hB);
      speed = 2'd3;
      start_pulse();
      repeat (5) tick();
      pause = 1'b1;
      tick();
      pause = 1'b0;
      check("paused_busy", busy, 8'h01);
      repeat (20) tick();
      check("paused_hex0", HEX0, 8'h7F);
      check("paused_busy2", busy, 8'h01);
      pause = 1'b1;
      tick();
      pause = 1'b0;
      repeat (10) tick();
      check("resume_e37_hex0", HEX0, 8'h7F);
      tick();
      check("resume_e38_hex0", HEX0, 8'h08);

      // Start corner cases
      clear_pulse();
      speed = 2'd0;
      start_pulse();
      check("start_empty_busy", busy, 8'h00);
      write_digit(4'h5);
      start = 1'b1; clear = 1'b1;
      tick();
      start = 1'b0; clear = 1'b0;
      check("start_clear_busy", busy, 8'h00);
      check("start_clear_len", len, 8'd0);
      write_digit(4'h7);
      start = 1'b1; wr_en = 1'b1; wr_data = 4'h9;
      tick();
      start = 1'b0; wr_en = 1'b0;
      check("start_wr_busy", busy, 8'h01);
      check("start_wr_len", len, 8'd1);
      repeat (5) tick();
      check("run7_hex0", HEX0, 8'h78);

      // Asynchronous reset mid-run
      #1;
      Resetn = 1'b0;
      #1;
      check("async_busy", busy, 8'h00);
      check("async_hex0", HEX0, 8'h7F);
      check("async_len", len, 8'h00);
      tick();
      tick();
      Resetn = 1'b1;
      tick();
      check("post_rst_busy", busy, 8'h00);
      check("post_rst_hex0", HEX0, 8'h7F);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hex_scroll_ctrl.md
HEX_SCROLL_CTRL -- requirements
Module: hex_scroll_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 25000000, meaning CLOCK_50 cycles per scroll tick (minimum 2).
REQ-002 SHALL have parameter MSG_MAX, default 16, meaning message buffer depth in 4-bit digits.
REQ-003 CLOCK_50  in  1  sole clock; all state changes on its rising edge.
REQ-004 Resetn  in  1  asynchronous, active-low reset.
REQ-005 wr_en  in  1  digit write strobe, one digit per cycle.
REQ-006 wr_data  in  4  hex digit to append.
REQ-007 start  in  1  single-cycle pulse, begins scrolling.
REQ-008 pause  in  1  single-cycle pulse, toggles RUN/PAUSE.
REQ-009 clear  in  1  single-cycle pulse, empties buffer and returns to IDLE.
REQ-010 speed  in  2  ticks per scroll step minus one.
REQ-011 wr_ready  out  1  write accepted this cycle if wr_en high.
REQ-012 busy  out  1  high in RUN or PAUSE.
REQ-013 len  out  5  digits stored, 0..MSG_MAX.
REQ-014 HEX0..HEX5  out  7 each  active-low segments {g,f,e,d,c,b,a}; HEX5 leftmost.

Function
REQ-015 States SHALL be IDLE, RUN, PAUSE; the state register is a 2-bit encoding.
REQ-016 wr_ready SHALL equal (state==IDLE && len<MSG_MAX && !start && !clear), combinational.
REQ-017 When wr_en && wr_ready, SHALL store wr_data at index len and increment len on the same edge; writes with wr_ready low are dropped and do not change state.
REQ-018 Event priority SHALL be clear > start > pause > write.
REQ-019 clear in any state SHALL set len=0, pos=0, prescaler=0, step count=0, state=IDLE on the next edge.
REQ-020 start in IDLE with len>=1 SHALL enter RUN with pos=0, prescaler=0, step count=0; start with len==0, or in RUN or PAUSE, SHALL be ignored.
REQ-021 pause in RUN SHALL enter PAUSE; pause in PAUSE SHALL enter RUN; pause in IDLE SHALL be ignored.
REQ-022 The prescaler SHALL count 0..TICK_DIV-1 only in RUN, and assert an internal one-cycle tick when at TICK_DIV-1 (then wrapping to 0).
REQ-023 In PAUSE, the prescaler, step count, pos and HEX SHALL hold.
REQ-024 On each tick: if step count >= speed, pos SHALL advance and step count SHALL clear; otherwise step count SHALL increment. speed is sampled live.
REQ-025 pos range SHALL be 0..len+5, and SHALL wrap to 0 after len+5 so the message loops continuously.
REQ-026 Define s[j] = buffer[j] for 0<=j<len, otherwise blank.
REQ-027 In RUN and PAUSE, HEXk SHALL show s[pos-1-k] for k=0..5, so pos=0 is all blank and digits enter at HEX0 and move left.
REQ-028 In IDLE, HEXk SHALL show s[len-1-k], so entry appears right-justified with the newest digit on HEX0.
REQ-029 HEX outputs SHALL be registered and reflect state/pos/len one cycle after they change.
REQ-030 Encodings SHALL be: blank=7'h7F, 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
REQ-031 busy SHALL be registered and equal (state!=IDLE).
REQ-032 len SHALL be a direct register output.

Reset
REQ-033 Resetn low SHALL immediately force: state=IDLE, len=0, pos=0, prescaler=0, step count=0, busy=0, HEX0..HEX5=7'h7F.
REQ-034 Buffer contents SHALL NOT be reset.
REQ-035 Reset asserted mid-RUN SHALL abort scrolling with no further tick.
REQ-036 Operation SHALL resume on the first rising edge after Resetn goes high.

Verification (TICK_DIV=4)
REQ-037 Reset, write 1,2,3 -> len=3; HEX0=79(3?no: digit 3)=30, HEX1=24, HEX2=79, HEX3..HEX5=7F, busy=0.
REQ-038 Write 17 digits -> len=16; wr_ready=0 after the 16th; the 17th is dropped.
REQ-039 Load A,b; speed=0; start -> busy=1, all blank.
   - After 4 cycles: HEX0=08.
   - After 8: HEX1=08, HEX0=03.
   - pos wraps to 0 after pos=7 (all blank).
REQ-040 RUN with speed=3; pause for 20 cycles; pause again -> HEX held throughout; the next step occurs exactly after the remaining ticks (16 cycles per step total).
REQ-041 start with len=0 -> busy stays 0.
   - start+clear same cycle -> IDLE, len=0.
   - start+wr_en in IDLE -> RUN, len unchanged.
REQ-042 Resetn low mid-RUN -> HEX all 7F and busy=0 asynchronously, before the next edge.
